// File: rtl/uparc_ibus_mem_if.sv
// rtl/uparc_ibus_mem_if.sv - Ultiparc I-Bus fetch channel between CPU fetch unit and instruction memory
interface uparc_ibus_mem_if;
    logic [31:0] i_IAddr;
    logic        i_IRdC;
    logic [31:0] o_IData;
    logic        o_IRdy;
    logic        o_IErr;

    modport master (
        output i_IAddr,
        output i_IRdC,
        input  o_IData,
        input  o_IRdy,
        input  o_IErr
    );

    modport slave (
        input  i_IAddr,
        input  i_IRdC,
        output o_IData,
        output o_IRdy,
        output o_IErr
    );
endinterface

// File: rtl/uparc_ibus_mem.sv
// rtl/uparc_ibus_mem.sv - I-Bus instruction-memory responder with wait states; UPARC_IBUS_MEM_BUF_EN adds a last-word buffer
module uparc_ibus_mem #(
    parameter int          MEM_AW      = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              nrst,
    uparc_ibus_mem_if.slave   bus,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [31:0]       i_mem_data,
    input  logic              inv
);
    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        cnt;
    logic [MEM_AW-1:0] word;
    logic              in_win;
    logic              hit;
    logic              fill;

    assign word       = bus.i_IAddr[MEM_AW+1:2];
    assign in_win     = bus.i_IAddr[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2];
    assign o_mem_addr = word;
    assign fill       = (state == MEM) && (cnt == 4'd0);

`ifdef UPARC_IBUS_MEM_BUF_EN
    logic              buf_valid;
    logic [MEM_AW-1:0] buf_tag;
    logic [31:0]       buf_data;

    assign hit = buf_valid && (buf_tag == word);

    // A simultaneous invalidate beats a fill so stale data can never be marked valid.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else begin
            if (fill) begin
                buf_tag  <= word;
                buf_data <= i_mem_data;
            end
            if (inv)
                buf_valid <= 1'b0;
            else if (fill)
                buf_valid <= 1'b1;
        end
    end

    wire unused_addr = ^bus.i_IAddr[1:0];
`else
    assign hit = 1'b0;

    wire unused_addr = ^{bus.i_IAddr[1:0], inv, fill};
`endif

    // Strobe only while sampling a new in-window miss; reset forces it low.
    assign o_mem_rd = nrst && (state == IDLE) && bus.i_IRdC && in_win && !hit;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            bus.o_IRdy  <= 1'b0;
            bus.o_IErr  <= 1'b0;
            bus.o_IData <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_IRdC) begin
                        if (!in_win) begin
                            bus.o_IErr <= 1'b1;
                            state      <= RESP;
                        end else if (hit) begin
`ifdef UPARC_IBUS_MEM_BUF_EN
                            bus.o_IData <= buf_data;
`endif
                            bus.o_IRdy  <= 1'b1;
                            state       <= RESP;
                        end else begin
                            cnt   <= WAIT_LOAD;
                            state <= MEM;
                        end
                    end
                end
                MEM: begin
                    if (cnt == 4'd0) begin
                        bus.o_IData <= i_mem_data;
                        bus.o_IRdy  <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // The request still on the bus belongs to the one just completed.
                    bus.o_IRdy  <= 1'b0;
                    bus.o_IErr  <= 1'b0;
                    bus.o_IData <= 32'd0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uparc_ibus_mem.sv
// tb/tb_uparc_ibus_mem.sv - scoreboard bench for uparc_ibus_mem with zero and three wait states
module tb_uparc_ibus_mem;
    localparam int W0 = 0;
    localparam int W1 = 3;
`ifdef UPARC_IBUS_MEM_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [13:0] ma0, ma1;
    logic        rd0, rd1;
    logic [31:0] md0 = 32'd0, md1 = 32'd0;
    logic        inv0 = 1'b0, inv1 = 1'b0;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rd_cnt [2];
    logic [13:0] exp_maddr [2];
    bit   resp_seen [2];
    bit   bv [2];
    logic [13:0] bt [2];
    bit   exp_miss [2];
    int   rd_base [2];
    int   last_t;
    exp_t q0 [$];
    exp_t q1 [$];

    uparc_ibus_mem_if b0 ();
    uparc_ibus_mem_if b1 ();

    uparc_ibus_mem #(.MEM_AW(14), .BASE_ADDR(32'h0), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .nrst(nrst), .bus(b0), .o_mem_addr(ma0), .o_mem_rd(rd0),
        .i_mem_data(md0), .inv(inv0));
    uparc_ibus_mem #(.MEM_AW(14), .BASE_ADDR(32'h0), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .nrst(nrst), .bus(b1), .o_mem_addr(ma1), .o_mem_rd(rd1),
        .i_mem_data(md1), .inv(inv1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sram_word(logic [13:0] a);
        if (a == 14'h10) return 32'hDEAD_BEEF;
        return {a, 2'b01, ~a, 2'b10};
    endfunction

    always @(posedge clk) begin
        if (rd0) md0 <= sram_word(ma0);
        if (rd1) md1 <= sram_word(ma1);
    end

    task automatic mon(int d, logic rdy, logic err, logic [31:0] data, logic rd, logic [13:0] ma);
        exp_t e;
        if (rd) begin
            rd_cnt[d]++;
            checks++;
            if (ma !== exp_maddr[d]) begin
                errors++;
                $display("FAIL mem_addr dut%0d: got %0h expected %0h", d, ma, exp_maddr[d]);
            end
        end
        checks++;
        if (rdy && err) begin
            errors++;
            $display("FAIL rdy_err_overlap dut%0d: got rdy=%0b err=%0b expected not both", d, rdy, err);
        end
        if (!rdy) begin
            checks++;
            if (data !== 32'd0) begin
                errors++;
                $display("FAIL idata_idle dut%0d: got %0h expected 0", d, data);
            end
        end
        if (rdy || err) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                errors++;
                checks++;
                $display("FAIL spurious_pulse dut%0d: got rdy=%0b err=%0b at cycle %0d expected none", d, rdy, err, cyc);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                checks++;
                if (cyc !== e.cyc || err !== e.err || data !== e.data) begin
                    errors++;
                    $display("FAIL response dut%0d: got cycle=%0d err=%0b data=%0h expected cycle=%0d err=%0b data=%0h",
                             d, cyc, err, data, e.cyc, e.err, e.data);
                end
            end
            resp_seen[d] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        mon(0, b0.o_IRdy, b0.o_IErr, b0.o_IData, rd0, ma0);
        mon(1, b1.o_IRdy, b1.o_IErr, b1.o_IData, rd1, ma1);
    end

    task automatic set_bus(int d, logic [31:0] a, logic c);
        if (d == 0) begin
            b0.i_IAddr = a;
            b0.i_IRdC  = c;
        end else begin
            b1.i_IAddr = a;
            b1.i_IRdC  = c;
        end
    endtask

    task automatic start_req(int d, logic [31:0] a);
        exp_t        e;
        logic [13:0] w;
        int          wt;
        wt = (d == 0) ? W0 : W1;
        w  = a[15:2];
        last_t = cyc;
        if (a[31:16] != 16'd0) begin
            e = '{cyc + 1, 1'b1, 32'd0};
            exp_miss[d] = 1'b0;
        end else if (BUF && bv[d] && bt[d] == w) begin
            e = '{cyc + 1, 1'b0, sram_word(w)};
            exp_miss[d] = 1'b0;
        end else begin
            e = '{cyc + 2 + wt, 1'b0, sram_word(w)};
            exp_miss[d] = 1'b1;
            bv[d] = 1'b1;
            bt[d] = w;
        end
        exp_maddr[d] = w;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        rd_base[d]   = rd_cnt[d];
        resp_seen[d] = 1'b0;
        set_bus(d, a, 1'b1);
    endtask

    task automatic finish_req(int d, logic [31:0] a, bit hold);
        int n;
        @(posedge clk) #1;
        inv0 = 1'b0;
        inv1 = 1'b0;
        if (!hold) set_bus(d, a, 1'b0);
        n = 0;
        while (!resp_seen[d] && n < 40) begin
            @(negedge clk) #1;
            n++;
        end
        checks++;
        if (!resp_seen[d]) begin
            errors++;
            $display("FAIL timeout dut%0d: got no response expected one within 40 cycles", d);
            if (d == 0) q0.delete(); else q1.delete();
        end
        checks++;
        if ((rd_cnt[d] - rd_base[d]) != int'(exp_miss[d])) begin
            errors++;
            $display("FAIL mem_rd_count dut%0d addr %0h: got %0d expected %0d", d, a, rd_cnt[d] - rd_base[d], exp_miss[d]);
        end
        @(posedge clk) #1;
        set_bus(d, a, 1'b0);
    endtask

    task automatic issue(int d, logic [31:0] a, bit hold);
        start_req(d, a);
        finish_req(d, a, hold);
    endtask

    task automatic check_quiet(string nm, int d, logic rdy, logic err, logic [31:0] data, logic rd);
        checks++;
        if (rdy !== 1'b0 || err !== 1'b0 || data !== 32'd0 || rd !== 1'b0) begin
            errors++;
            $display("FAIL %s dut%0d: got rdy=%0b err=%0b data=%0h rd=%0b expected all 0", nm, d, rdy, err, data, rd);
        end
    endtask

    task automatic test_reset;
        set_bus(0, 32'h40, 1'b1);
        set_bus(1, 32'h40, 1'b1);
        #2 nrst = 1'b0;
        #1;
        check_quiet("reset_state", 0, b0.o_IRdy, b0.o_IErr, b0.o_IData, rd0);
        check_quiet("reset_state", 1, b1.o_IRdy, b1.o_IErr, b1.o_IData, rd1);
        set_bus(0, 32'h0, 1'b0);
        set_bus(1, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_zero_wait;
        issue(0, 32'h40, 1'b1);
        issue(0, 32'h44, 1'b1);
        issue(0, 32'h0000_FFFC, 1'b1);
    endtask

    task automatic test_back_to_back;
        int t1;
        issue(1, 32'h0, 1'b1);
        t1 = last_t;
        issue(1, 32'h4, 1'b1);
        checks++;
        if (last_t - t1 != 6) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected 6", last_t - t1);
        end
    endtask

    task automatic test_error;
        issue(1, 32'h0001_0000, 1'b1);
        issue(1, 32'hFFFF_FFFC, 1'b1);
        issue(0, 32'h0001_0000, 1'b1);
        issue(0, 32'h8000_0040, 1'b0);
    endtask

    task automatic test_drop;
        issue(1, 32'h100, 1'b0);
        issue(0, 32'h104, 1'b0);
        issue(1, 32'h108, 1'b1);
    endtask

    task automatic test_buffer;
        issue(1, 32'h40, 1'b1);
        issue(1, 32'h40, 1'b1);
        issue(1, 32'h44, 1'b1);
        inv1 = 1'b1;
        @(posedge clk) #1;
        inv1 = 1'b0;
        bv[1] = 1'b0;
        issue(1, 32'h44, 1'b1);
        // invalidate raised in the hit sampling cycle
        inv1 = 1'b1;
        issue(1, 32'h44, 1'b1);
        bv[1] = 1'b0;
        issue(1, 32'h44, 1'b1);
        // invalidate coinciding with the fill edge
        start_req(0, 32'h80);
        @(posedge clk) #1;
        inv0 = 1'b1;
        finish_req(0, 32'h80, 1'b1);
        bv[0] = 1'b0;
        issue(0, 32'h80, 1'b1);
        issue(0, 32'h80, 1'b1);
    endtask

    task automatic test_reset_mid;
        start_req(1, 32'h40);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        check_quiet("reset_mid", 1, b1.o_IRdy, b1.o_IErr, b1.o_IData, rd1);
        check_quiet("reset_mid", 0, b0.o_IRdy, b0.o_IErr, b0.o_IData, rd0);
        q1.delete();
        bv[0] = 1'b0;
        bv[1] = 1'b0;
        set_bus(1, 32'h40, 1'b0);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        issue(1, 32'h40, 1'b1);
    endtask

    initial begin
        rd_cnt[0] = 0; rd_cnt[1] = 0;
        bv[0] = 1'b0; bv[1] = 1'b0;
        bt[0] = '0; bt[1] = '0;
        exp_maddr[0] = '0; exp_maddr[1] = '0;
        set_bus(0, 32'h0, 1'b0);
        set_bus(1, 32'h0, 1'b0);
        test_reset;
        test_zero_wait;
        test_back_to_back;
        test_error;
        test_drop;
        test_buffer;
        test_reset_mid;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d/%0d outstanding expected 0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
